// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and sizing helpers for the frequency meter.
//   state_t  - measurement FSM states (IDLE, GATE, DONE)
//   gate_w() - width of the gate-window down-counter for a given window length
//   cnt_max() - saturation ceiling of an edge accumulator of a given width
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter is loaded with gate_cycles-1, so $clog2(gate_cycles) bits suffice.
  function automatic int gate_w(input int gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

  function automatic longint unsigned cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings an asynchronous single-bit input into the clk domain
// and flags its rising edges.
//   clk     - system clock
//   rst     - synchronous active-high reset, clears all flops
//   d_async - asynchronous input
//   d_sync  - synchronized level (second synchronizer flop)
//   rise    - one-cycle pulse on each synchronized 0->1 transition
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign d_sync = s2;
  assign rise   = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of f_in over a window of GATE_CYCLES clocks
// and presents the result with a valid/ack handshake.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   f_in  - signal under measurement (may be asynchronous)
//   start - request a measurement, taken only in IDLE
//   ack   - consumer acknowledges the result, taken only while valid
//   count - edges counted in the last completed window (saturating)
//   valid - count holds a completed, unacknowledged result
//   busy  - gate window in progress
//   ovf   - accumulator saturated during the last completed window
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  input  logic             start,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  localparam int               GATE_W    = gate_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_max(CNT_W));

  state_t            state;
  state_t            state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic              arm;
  logic [CNT_W-1:0]  acc;
  logic              acc_ovf;
  logic [CNT_W-1:0]  acc_nxt;
  logic              acc_ovf_nxt;
  logic              edge_p0;
  logic              f_sync_unused;
  logic              last_cycle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: synchronized edge pulse
  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (f_in),
    .d_sync  (f_sync_unused),
    .rise    (edge_p0)
  );

  // The first GATE cycle after start only drops arm; the counted window is
  // the GATE_CYCLES cycles that follow it.
  assign last_cycle  = (state == GATE) && !arm && (gate_cnt == '0);
  assign acc_nxt     = edge_p0 ? sat_inc(acc) : acc;
  assign acc_ovf_nxt = acc_ovf | (edge_p0 && (acc == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = GATE;
      GATE:    if (last_cycle) state_nxt = DONE;
      DONE:    if (ack)        state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Stage p1: gate counter, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      arm      <= 1'b0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gate_cnt <= GATE_LOAD;
            arm      <= 1'b1;
            acc      <= '0;
            acc_ovf  <= 1'b0;
          end
        end
        GATE: begin
          if (arm) begin
            arm <= 1'b0;
          end else begin
            acc      <= acc_nxt;
            acc_ovf  <= acc_ovf_nxt;
            gate_cnt <= gate_cnt - GATE_W'(1);
            if (gate_cnt == '0) begin
              count <= acc_nxt;
              ovf   <= acc_ovf_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state == GATE);

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  localparam int G = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_in;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] count;
  logic        valid, busy, ovf;
  logic [5:0]  count6;
  logic        valid6, busy6, ovf6;

  int checks = 0;
  int failures = 0;

  int   mode = 0;      // 0 hold, 1 clk/2, 2 clk/4, 3 clk/8
  logic hold_lvl = 1'b0;

  int   exp_cnt_q[$];
  bit   exp_ovf_q[$];
  int   exp_cnt6_q[$];
  bit   exp_ovf6_q[$];

  freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .f_in(f_in), .start(start), .ack(ack),
    .count(count), .valid(valid), .busy(busy), .ovf(ovf)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(6)) dut6 (
    .clk(clk), .rst(rst), .f_in(f_in), .start(start), .ack(ack),
    .count(count6), .valid(valid6), .busy(busy6), .ovf(ovf6)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    f_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph++;
      case (mode)
        1:       f_in = ph[0];
        2:       f_in = ph[1];
        3:       f_in = ph[2];
        default: f_in = hold_lvl;
      endcase
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full measurement on both DUTs; poke drives start during GATE, in
  // DONE and alongside ack, all of which must be ignored.
  task automatic measure(input string name, input int e16, input int e6,
                         input bit o6, input bit poke);
    int lat;
    int ec, ec6;
    bit eo, eo6;
    exp_cnt_q.push_back(e16);
    exp_ovf_q.push_back(1'b0);
    exp_cnt6_q.push_back(e6);
    exp_ovf6_q.push_back(o6);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after_start: busy=%b valid=%b want busy=1 valid=0", name, busy, valid);
    end
    lat = 0;
    while (valid !== 1'b1 && lat < 400) begin
      start = (poke && (lat == 50 || lat == 51));
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    ec  = exp_cnt_q.pop_front();
    eo  = exp_ovf_q.pop_front();
    ec6 = exp_cnt6_q.pop_front();
    eo6 = exp_ovf6_q.pop_front();
    checks++;
    if (lat != G + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, lat, G + 1);
    end
    checks++;
    if (count !== 16'(ec) || ovf !== eo || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_result: count=%0d ovf=%b busy=%b want count=%0d ovf=%b busy=0",
               name, count, ovf, busy, ec, eo);
    end
    checks++;
    if (valid6 !== 1'b1 || count6 !== 6'(ec6) || ovf6 !== eo6) begin
      failures++;
      $display("FAIL %s_result_w6: valid=%b count=%0d ovf=%b want valid=1 count=%0d ovf=%b",
               name, valid6, count6, ovf6, ec6, eo6);
    end
    // Hold in DONE for a few cycles
    start = poke;
    wait_cycles(3);
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || count !== 16'(ec)) begin
      failures++;
      $display("FAIL %s_hold_done: valid=%b busy=%b count=%0d want valid=1 busy=0 count=%0d",
               name, valid, busy, count, ec);
    end
    ack = 1'b1;
    start = poke;
    @(posedge clk);
    #1;
    ack = 1'b0;
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 16'(ec) || ovf !== eo) begin
      failures++;
      $display("FAIL %s_after_ack: valid=%b busy=%b count=%0d ovf=%b want valid=0 busy=0 count=%0d ovf=%b",
               name, valid, busy, count, ovf, ec, eo);
    end
    if (poke) begin
      wait_cycles(5);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || valid6 !== 1'b0 || busy6 !== 1'b0) begin
        failures++;
        $display("FAIL %s_idle_after_poke: valid=%b busy=%b want 0 0", name, valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (count !== 16'd0 || valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 ||
        count6 !== 6'd0 || valid6 !== 1'b0 || busy6 !== 1'b0 || ovf6 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%0d valid=%b busy=%b ovf=%b want all 0", count, valid, busy, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_div2_then_div8();
    mode = 1;
    wait_cycles(6);
    measure("div2", 128, 63, 1'b1, 1'b0);
    mode = 3;
    wait_cycles(6);
    measure("div8", 32, 32, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    mode = 2;
    wait_cycles(6);
    for (int i = 0; i < 3; i++) measure("div4_b2b", 64, 63, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    mode = 1;
    wait_cycles(4);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cycles(100);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 16'd0 || ovf6 !== 1'b0 || count6 !== 6'd0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b valid=%b count=%0d count6=%0d want 0 0 0 0", busy, valid, count, count6);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(6);
    measure("after_reset", 128, 63, 1'b1, 1'b0);
  endtask

  task automatic test_const();
    mode = 0;
    hold_lvl = 1'b0;
    wait_cycles(8);
    measure("hold0", 0, 0, 1'b0, 1'b0);
    hold_lvl = 1'b1;
    wait_cycles(8);
    measure("hold1", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_toggle();
    mode = 1;
    wait_cycles(50);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 16'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL idle_toggle: valid=%b busy=%b count=%0d ovf=%b want 0 0 0 0", valid, busy, count, ovf);
    end
  endtask

  task automatic test_start_ignored();
    mode = 1;
    wait_cycles(4);
    measure("poke", 128, 63, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_div2_then_div8();
    test_back_to_back();
    test_mid_reset();
    test_const();
    test_idle_toggle();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
